// File: rtl/bit_run_encoder.sv
// bit_run_encoder
//   Run-length encodes a 1-bit sample stream into (bit, length) tokens.
//   Tokens go into a first-word-fall-through FIFO and leave on a
//   valid/ready port. A token that arrives while the FIFO is full is dropped
//   and sets a sticky overflow flag.
//
//   Optional build macro: UNIT_DELAY_EN. When it is defined, every register
//   update carries an intra-assignment #1, so registered outputs change 1ns
//   after the clk or rst edge. Cycle behaviour is the same in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   in_vld     in   din carries a valid sample this cycle
//   din        in   sample bit
//   flush      in   close the open run and emit it as a token
//   tok_valid  out  FIFO head token valid
//   tok_ready  in   consumer accepts the head token
//   tok_bit    out  head token run bit
//   tok_len    out  head token run length, 1..2**CNT_W-1
//   fifo_cnt   out  number of buffered tokens
//   overflow   out  sticky: a token was dropped
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no open run, cur_len = 0
// RUN   | open run of cur_len samples of value cur_bit
`timescale 1ns/100ps

`ifdef UNIT_DELAY_EN
  `define BRE_DLY #1
`else
  `define BRE_DLY
`endif

module bit_run_encoder #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_vld,
  input  logic                          din,
  input  logic                          flush,
  output logic                          tok_valid,
  input  logic                          tok_ready,
  output logic                          tok_bit,
  output logic [CNT_W-1:0]              tok_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] RMAX    = '1;
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic              cur_bit_q, cur_bit_d;
  logic [CNT_W-1:0]  cur_len_q, cur_len_d;

  logic              mem_bit_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_len_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              overflow_q;

  logic              push, pop, accept;
  logic              push_bit;
  logic [CNT_W-1:0]  push_len;

  // Run tracking: at most one token is closed per cycle.
  always_comb begin
    state_d   = state_q;
    cur_bit_d = cur_bit_q;
    cur_len_d = cur_len_q;
    push      = 1'b0;
    push_bit  = cur_bit_q;
    push_len  = cur_len_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          state_d   = S_RUN;
          cur_bit_d = din;
          cur_len_d = CNT_W'(1);
        end
      end
      S_RUN: begin
        if (flush) begin
          push = 1'b1;
          if (in_vld) begin
            cur_bit_d = din;
            cur_len_d = CNT_W'(1);
          end else begin
            state_d   = S_IDLE;
            cur_len_d = '0;
          end
        end else if (in_vld) begin
          if (din == cur_bit_q) begin
            if (cur_len_q == RMAX) begin
              // A saturated run is emitted and this sample opens the next one.
              push      = 1'b1;
              cur_len_d = CNT_W'(1);
            end else begin
              cur_len_d = cur_len_q + CNT_W'(1);
            end
          end else begin
            push      = 1'b1;
            cur_bit_d = din;
            cur_len_d = CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still takes a token if the head leaves in the same cycle.
  assign tok_valid = (cnt_q != '0);
  assign pop       = tok_valid & tok_ready;
  assign accept    = push & ((cnt_q < DEPTH_C) | pop);
  assign cnt_d     = cnt_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= `BRE_DLY S_IDLE;
      cur_bit_q  <= `BRE_DLY 1'b0;
      cur_len_q  <= `BRE_DLY '0;
      wr_ptr_q   <= `BRE_DLY '0;
      rd_ptr_q   <= `BRE_DLY '0;
      cnt_q      <= `BRE_DLY '0;
      overflow_q <= `BRE_DLY 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_bit_q[i] <= `BRE_DLY 1'b0;
        mem_len_q[i] <= `BRE_DLY '0;
      end
    end else begin
      state_q   <= `BRE_DLY state_d;
      cur_bit_q <= `BRE_DLY cur_bit_d;
      cur_len_q <= `BRE_DLY cur_len_d;
      cnt_q     <= `BRE_DLY cnt_d;
      if (accept) begin
        mem_bit_q[wr_ptr_q] <= `BRE_DLY push_bit;
        mem_len_q[wr_ptr_q] <= `BRE_DLY push_len;
        wr_ptr_q            <= `BRE_DLY wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= `BRE_DLY rd_ptr_q + AW'(1);
      end
      if (push && !accept) begin
        overflow_q <= `BRE_DLY 1'b1;
      end
    end
  end

  // Head is held at zero while empty so stale storage never shows.
  assign tok_bit  = tok_valid & mem_bit_q[rd_ptr_q];
  assign tok_len  = tok_valid ? mem_len_q[rd_ptr_q] : '0;
  assign fifo_cnt = cnt_q;
  assign overflow = overflow_q;

endmodule

`undef BRE_DLY

// File: tb/tb_bit_run_encoder.sv
`timescale 1ns/100ps

module tb_bit_run_encoder;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int RMAX  = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_vld = 1'b0, din = 1'b0, flush = 1'b0, tok_ready = 1'b0;
  logic             tok_valid, tok_bit, overflow;
  logic [CNT_W-1:0] tok_len;
  logic [2:0]       fifo_cnt;

  int n_vec = 0;
  int n_err = 0;

  bit_run_encoder #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .din(din), .flush(flush),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_bit(tok_bit),
    .tok_len(tok_len), .fifo_cnt(fifo_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: an open run plus a bounded queue of {bit, length}.
  int m_q_bit[$];
  int m_q_len[$];
  bit m_open;
  int m_bit;
  int m_len;
  bit m_ovf;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q_bit.delete();
    m_q_len.delete();
    m_open = 0; m_bit = 0; m_len = 0; m_ovf = 0;
  endtask

  task automatic model_clock(input bit v, input bit d, input bit f, input bit r);
    bit do_push = 0;
    int pb = 0, pl = 0;
    bit do_pop = (m_q_bit.size() != 0) && r;
    if (m_open) begin
      if (f) begin
        do_push = 1; pb = m_bit; pl = m_len;
        if (v) begin m_bit = d; m_len = 1; end
        else   begin m_open = 0; m_len = 0; end
      end else if (v) begin
        if (d == m_bit) begin
          if (m_len == RMAX) begin do_push = 1; pb = m_bit; pl = RMAX; m_len = 1; end
          else m_len++;
        end else begin
          do_push = 1; pb = m_bit; pl = m_len; m_bit = d; m_len = 1;
        end
      end
    end else if (v) begin
      m_open = 1; m_bit = d; m_len = 1;
    end
    if (do_pop) begin
      void'(m_q_bit.pop_front());
      void'(m_q_len.pop_front());
    end
    if (do_push) begin
      if (m_q_bit.size() < DEPTH) begin
        m_q_bit.push_back(pb);
        m_q_len.push_back(pl);
      end else m_ovf = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    bit v = (m_q_bit.size() != 0);
    check_eq({tag, ".valid"}, int'(tok_valid), int'(v));
    check_eq({tag, ".bit"},   int'(tok_bit),   v ? m_q_bit[0] : 0);
    check_eq({tag, ".len"},   int'(tok_len),   v ? m_q_len[0] : 0);
    check_eq({tag, ".cnt"},   int'(fifo_cnt),  m_q_bit.size());
    check_eq({tag, ".ovf"},   int'(overflow),  int'(m_ovf));
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic step(input string tag, input bit v, input bit d, input bit f, input bit r);
    in_vld = v; din = d; flush = f; tok_ready = r;
    @(posedge clk);
    model_clock(v, d, f, r);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    bit rd;
    model_reset();
    #2;
    check_eq("rst.valid", int'(tok_valid), 0);
    check_eq("rst.cnt",   int'(fifo_cnt),  0);
    check_eq("rst.len",   int'(tok_len),   0);
    check_eq("rst.ovf",   int'(overflow),  0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // T1: three tokens buffered plus an open run, then async reset mid-cycle.
    step("t1", 1, 0, 0, 0);
    step("t1", 1, 1, 0, 0);
    step("t1", 1, 0, 0, 0);
    step("t1", 1, 1, 0, 0);
    check_eq("t1.cnt3", int'(fifo_cnt), 3);
    #2 rst = 1'b0;
    #2;
    check_eq("t1.async_valid", int'(tok_valid), 0);
    check_eq("t1.async_cnt",   int'(fifo_cnt),  0);
    check_eq("t1.async_ovf",   int'(overflow),  0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step("t1.flush_idle", 0, 0, 1, 1);
    check_eq("t1.no_tok", int'(tok_valid), 0);

    // T2: 1,1,1,0 -> token (1,3), open run (0,1).
    step("t2", 1, 1, 0, 1);
    step("t2", 1, 1, 0, 1);
    step("t2", 1, 1, 0, 1);
    step("t2", 1, 0, 0, 1);
    check_eq("t2.valid", int'(tok_valid), 1);
    check_eq("t2.bit",   int'(tok_bit),   1);
    check_eq("t2.len",   int'(tok_len),   3);
    step("t2", 0, 0, 1, 1);
    check_eq("t2.open_bit", int'(tok_bit), 0);
    check_eq("t2.open_len", int'(tok_len), 1);
    step("t2.drain", 0, 0, 0, 1);

    // T3: 256 ones then flush -> (1,255), (1,1), FSM idle.
    for (int i = 0; i < 256; i++) step("t3", 1, 1, 0, 0);
    step("t3", 0, 0, 1, 0);
    check_eq("t3.cnt",  int'(fifo_cnt), 2);
    check_eq("t3.len0", int'(tok_len),  255);
    step("t3", 0, 0, 0, 1);
    check_eq("t3.bit1", int'(tok_bit), 1);
    check_eq("t3.len1", int'(tok_len), 1);
    step("t3", 0, 0, 0, 1);
    step("t3.idle_flush", 0, 0, 1, 1);
    check_eq("t3.idle", int'(tok_valid), 0);

    // T4: five tokens closed into a 4-deep FIFO with no consumer.
    for (int i = 0; i < 6; i++) step("t4", 1, i[0], 0, 0);
    check_eq("t4.cnt", int'(fifo_cnt), 4);
    check_eq("t4.ovf", int'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t4.seq_bit", int'(tok_bit), i % 2);
      check_eq("t4.seq_len", int'(tok_len), 1);
      step("t4.pop", 0, 0, 0, 1);
    end
    step("t4.close", 0, 0, 1, 1);
    step("t4.drain", 0, 0, 0, 1);

    // T5: open run (0,5), then flush together with a 1 sample.
    for (int i = 0; i < 5; i++) step("t5", 1, 0, 0, 0);
    step("t5", 1, 1, 1, 0);
    check_eq("t5.bit", int'(tok_bit), 0);
    check_eq("t5.len", int'(tok_len), 5);
    step("t5", 0, 0, 1, 1);
    check_eq("t5.open_bit", int'(tok_bit), 1);
    check_eq("t5.open_len", int'(tok_len), 1);
    step("t5.drain", 0, 0, 0, 1);

    // T6: edge-to-output timing of tok_valid on a push into an empty FIFO.
    step("t6", 1, 0, 0, 0);
    in_vld = 1; din = 1; flush = 0; tok_ready = 0;
    @(posedge clk);
    model_clock(1, 1, 0, 0);
    #0.5;
`ifdef UNIT_DELAY_EN
    check_eq("t6.before_1ns", int'(tok_valid), 0);
`else
    check_eq("t6.before_1ns", int'(tok_valid), 1);
`endif
    #1.0;
    check_eq("t6.after_1ns", int'(tok_valid), 1);
    @(negedge clk);
    compare_all("t6");
    step("t6.close", 0, 0, 1, 1);
    step("t6.drain", 0, 0, 0, 1);
    step("t6.drain", 0, 0, 0, 1);

    // Randomized traffic with biased run lengths and bursty backpressure.
    rd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      step("rnd", $urandom_range(0, 3) != 0, rd,
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) rd = ~rd;
      step("rnd_long", 1, rd, $urandom_range(0, 299) == 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
